// File: rtl/frog_control_pkg.sv
// Shared game constants: grid geometry, output widths and FSM state encodings.
// Imported by the frog controller, the collision checker and the renderer.
package frog_control_pkg;

    localparam int unsigned GAME_TILE_SIZE = 32;
    localparam int unsigned GAME_GRID_COLS = 20;
    localparam int unsigned GAME_GRID_ROWS = 15;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] S_PLAY      = 2'd1;
    localparam logic [STATE_W-1:0] S_HIT       = 2'd2;
    localparam logic [STATE_W-1:0] S_GAME_OVER = 2'd3;

    // One rising-edge strobe per button.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic start;
    } btn_edges_t;

endpackage

// File: rtl/frog_control_if.sv
// Frog controller bus: button and collision inputs, frog state outputs.
// master: the side driving buttons/collision (board glue or bench).
// slave : the frog controller.
interface frog_control_if;
    import frog_control_pkg::*;

    logic               i_Up;
    logic               i_Down;
    logic               i_Left;
    logic               i_Right;
    logic               i_Start;
    logic               i_Has_Collided;
    logic [POS_W-1:0]   o_Frog_X;
    logic [POS_W-1:0]   o_Frog_Y;
    logic [LIVES_W-1:0] o_Lives;
    logic [LEVEL_W-1:0] o_Level;
    logic               o_Hit_Active;
    logic               o_Game_Over;

    modport master (
        output i_Up, i_Down, i_Left, i_Right, i_Start, i_Has_Collided,
        input  o_Frog_X, o_Frog_Y, o_Lives, o_Level, o_Hit_Active, o_Game_Over
    );

    modport slave (
        input  i_Up, i_Down, i_Left, i_Right, i_Start, i_Has_Collided,
        output o_Frog_X, o_Frog_Y, o_Lives, o_Level, o_Hit_Active, o_Game_Over
    );

endinterface

// File: rtl/frog_control_button_edge.sv
// Rising-edge detector for one debounced button level.
// Ports: i_clk, i_rst (sync, active-high), i_level in; o_rise_c combinational
// strobe, high for the one cycle in which the level first reads high.
module button_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise_c
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = i_level;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_rise_c = i_level & ~prev_q;

endmodule

// File: rtl/frog_control.sv
// Frog controller: game FSM (IDLE/PLAY/HIT/GAME_OVER), tile-stepped frog
// movement with edge clamping, lives, crossing level and death freeze.
// Ports: i_Clk, i_Reset (sync, active-high); bus (slave) carries button and
// collision inputs and the registered frog position/lives/level/status outputs.
module frog_control
    import frog_control_pkg::*;
#(
    parameter int unsigned TILE_SIZE    = GAME_TILE_SIZE,
    parameter int unsigned GRID_COLS    = GAME_GRID_COLS,
    parameter int unsigned GRID_ROWS    = GAME_GRID_ROWS,
    parameter int unsigned DEATH_CYCLES = 25_000_000,
    parameter int unsigned START_LIVES  = 3
) (
    input  logic          i_Clk,
    input  logic          i_Reset,
    frog_control_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEATH_CYCLES) + 1;

    localparam logic [POS_W-1:0]   TILE    = POS_W'(TILE_SIZE);
    localparam logic [POS_W-1:0]   START_X = POS_W'((GRID_COLS / 2) * TILE_SIZE);
    localparam logic [POS_W-1:0]   START_Y = POS_W'((GRID_ROWS - 1) * TILE_SIZE);
    localparam logic [POS_W-1:0]   MAX_X   = POS_W'((GRID_COLS - 1) * TILE_SIZE);
    localparam logic [POS_W-1:0]   MAX_Y   = POS_W'((GRID_ROWS - 1) * TILE_SIZE);
    localparam logic [LIVES_W-1:0] LIVES0  = LIVES_W'(START_LIVES);
    localparam logic [CNT_W-1:0]   FREEZE  = CNT_W'(DEATH_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX = {LEVEL_W{1'b1}};

    btn_edges_t rise_c;

    logic [STATE_W-1:0] state_q, state_d;
    logic [POS_W-1:0]   pos_x_q, pos_x_d;
    logic [POS_W-1:0]   pos_y_q, pos_y_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               hit_q,   hit_d;
    logic               over_q,  over_d;

    button_edge u_edge_up    (.i_clk(i_Clk), .i_rst(i_Reset), .i_level(bus.i_Up),    .o_rise_c(rise_c.up));
    button_edge u_edge_down  (.i_clk(i_Clk), .i_rst(i_Reset), .i_level(bus.i_Down),  .o_rise_c(rise_c.down));
    button_edge u_edge_left  (.i_clk(i_Clk), .i_rst(i_Reset), .i_level(bus.i_Left),  .o_rise_c(rise_c.left));
    button_edge u_edge_right (.i_clk(i_Clk), .i_rst(i_Reset), .i_level(bus.i_Right), .o_rise_c(rise_c.right));
    button_edge u_edge_start (.i_clk(i_Clk), .i_rst(i_Reset), .i_level(bus.i_Start), .o_rise_c(rise_c.start));

    // Next-state and datapath. Edges are only strobes, so anything pressed
    // outside PLAY is simply dropped rather than queued.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        lives_d = lives_q;
        level_d = level_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (rise_c.start) begin
                    state_d = S_PLAY;
                    pos_x_d = START_X;
                    pos_y_d = START_Y;
                    lives_d = LIVES0;
                    level_d = '0;
                end
            end
            S_PLAY: begin
                if (bus.i_Has_Collided) begin
                    state_d = S_HIT;
                    cnt_d   = FREEZE;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else if (pos_y_q == '0) begin
                    pos_x_d = START_X;
                    pos_y_d = START_Y;
                    if (level_q != LVL_MAX) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                end else if (rise_c.up) begin
                    // Highest-priority edge wins even if its move is blocked.
                    if (pos_y_q >= TILE) begin
                        pos_y_d = pos_y_q - TILE;
                    end
                end else if (rise_c.down) begin
                    if (pos_y_q < MAX_Y) begin
                        pos_y_d = pos_y_q + TILE;
                    end
                end else if (rise_c.left) begin
                    if (pos_x_q >= TILE) begin
                        pos_x_d = pos_x_q - TILE;
                    end
                end else if (rise_c.right) begin
                    if (pos_x_q < MAX_X) begin
                        pos_x_d = pos_x_q + TILE;
                    end
                end
            end
            S_HIT: begin
                if (cnt_q == '0) begin
                    if (lives_q != '0) begin
                        state_d = S_PLAY;
                        pos_x_d = START_X;
                        pos_y_d = START_Y;
                    end else begin
                        state_d = S_GAME_OVER;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hit_d  = (state_d == S_HIT);
        over_d = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            pos_x_q <= START_X;
            pos_y_q <= START_Y;
            lives_q <= LIVES0;
            level_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            lives_q <= lives_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            over_q  <= over_d;
        end
    end

    assign bus.o_Frog_X     = pos_x_q;
    assign bus.o_Frog_Y     = pos_y_q;
    assign bus.o_Lives      = lives_q;
    assign bus.o_Level      = level_q;
    assign bus.o_Hit_Active = hit_q;
    assign bus.o_Game_Over  = over_q;

endmodule

// File: tb/tb_frog_control.sv
// Self-checking bench for frog_control with DEATH_CYCLES=4. Each step drives
// one cycle of inputs, pushes the expected outputs into a scoreboard queue,
// and pops/compares them once the DUT has clocked.
module tb_frog_control;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b10000;
    localparam logic [4:0] B_DOWN  = 5'b01000;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b00010;
    localparam logic [4:0] B_START = 5'b00001;

    typedef struct {
        string tag;
        int    x;
        int    y;
        int    lives;
        int    level;
        int    hit;
        int    over;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    frog_control_if bus ();

    frog_control #(
        .TILE_SIZE   (32),
        .GRID_COLS   (20),
        .GRID_ROWS   (15),
        .DEATH_CYCLES(4),
        .START_LIVES (3)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue its expected result, clock, then score it.
    task automatic step(input logic r, input logic [4:0] b, input logic col,
                        input int x, input int y, input int lv, input int lvl,
                        input int h, input int g, input string tag);
        exp_t e;
        rst                = r;
        bus.i_Up           = b[4];
        bus.i_Down         = b[3];
        bus.i_Left         = b[2];
        bus.i_Right        = b[1];
        bus.i_Start        = b[0];
        bus.i_Has_Collided = col;
        sb.push_back('{tag, x, y, lv, lvl, h, g});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".x"},     32'(bus.o_Frog_X),     32'(e.x));
            check({e.tag, ".y"},     32'(bus.o_Frog_Y),     32'(e.y));
            check({e.tag, ".lives"}, 32'(bus.o_Lives),      32'(e.lives));
            check({e.tag, ".level"}, 32'(bus.o_Level),      32'(e.level));
            check({e.tag, ".hit"},   32'(bus.o_Hit_Active), 32'(e.hit));
            check({e.tag, ".over"},  32'(bus.o_Game_Over),  32'(e.over));
        end
    endtask

    initial begin
        bus.i_Up           = 1'b0;
        bus.i_Down         = 1'b0;
        bus.i_Left         = 1'b0;
        bus.i_Right        = 1'b0;
        bus.i_Start        = 1'b0;
        bus.i_Has_Collided = 1'b0;
        #2;

        // Reset and start.
        step(1, B_NONE,  0, 320, 448, 3, 0, 0, 0, "reset");
        step(0, B_UP,    0, 320, 448, 3, 0, 0, 0, "idle_up_ignored");
        step(0, B_NONE,  0, 320, 448, 3, 0, 0, 0, "idle");
        step(0, B_START, 0, 320, 448, 3, 0, 0, 0, "start");
        step(0, B_UP,    0, 320, 416, 3, 0, 0, 0, "up1");
        step(0, B_NONE,  0, 320, 416, 3, 0, 0, 0, "up1_rel");
        step(0, B_UP,    0, 320, 384, 3, 0, 0, 0, "up2");
        step(0, B_UP,    0, 320, 384, 3, 0, 0, 0, "up_held");
        step(0, B_NONE,  0, 320, 384, 3, 0, 0, 0, "up_rel");

        // Walk left to the edge, then hold Left against it.
        for (int i = 0; i < 10; i++) begin
            step(0, B_LEFT, 0, 320 - 32 * (i + 1), 384, 3, 0, 0, 0, "left_step");
            step(0, B_NONE, 0, 320 - 32 * (i + 1), 384, 3, 0, 0, 0, "left_rel");
        end
        for (int i = 0; i < 10; i++) begin
            step(0, B_LEFT, 0, 0, 384, 3, 0, 0, 0, "left_held_at_0");
        end
        step(0, B_NONE, 0, 0, 384, 3, 0, 0, 0, "left_rel_at_0");

        // Priority: Up beats Right.
        step(0, B_UP | B_RIGHT, 0, 0, 352, 3, 0, 0, 0, "up_right");
        step(0, B_NONE,         0, 0, 352, 3, 0, 0, 0, "up_right_rel");

        // Down to the bottom edge and one more against it.
        for (int i = 0; i < 3; i++) begin
            step(0, B_DOWN, 0, 0, 384 + 32 * i, 3, 0, 0, 0, "down_step");
            step(0, B_NONE, 0, 0, 384 + 32 * i, 3, 0, 0, 0, "down_rel");
        end
        step(0, B_DOWN, 0, 0, 448, 3, 0, 0, 0, "down_at_bottom");
        step(0, B_NONE, 0, 0, 448, 3, 0, 0, 0, "down_rel_bottom");

        // First hit: 4 frozen cycles, Up ignored, held Up not replayed after.
        step(0, B_NONE, 1, 0,   448, 2, 0, 1, 0, "hit1");
        step(0, B_UP,   0, 0,   448, 2, 0, 1, 0, "hit1_up");
        step(0, B_NONE, 0, 0,   448, 2, 0, 1, 0, "hit1_rel");
        step(0, B_UP,   0, 0,   448, 2, 0, 1, 0, "hit1_up2");
        step(0, B_UP,   0, 320, 448, 2, 0, 0, 0, "hit1_exit");
        step(0, B_UP,   0, 320, 448, 2, 0, 0, 0, "hit1_no_replay");
        step(0, B_NONE, 0, 320, 448, 2, 0, 0, 0, "hit1_rel2");

        // Second hit with collision held throughout the freeze.
        step(0, B_NONE, 1, 320, 448, 1, 0, 1, 0, "hit2");
        for (int i = 0; i < 3; i++) begin
            step(0, B_NONE, 1, 320, 448, 1, 0, 1, 0, "hit2_col_ignored");
        end
        step(0, B_NONE, 0, 320, 448, 1, 0, 0, 0, "hit2_exit");

        // Third hit leads to game over.
        step(0, B_NONE, 1, 320, 448, 0, 0, 1, 0, "hit3");
        for (int i = 0; i < 3; i++) begin
            step(0, B_NONE, 0, 320, 448, 0, 0, 1, 0, "hit3_freeze");
        end
        step(0, B_NONE,  0, 320, 448, 0, 0, 0, 1, "game_over");
        step(0, B_UP,    0, 320, 448, 0, 0, 0, 1, "game_over_hold");
        step(0, B_NONE,  0, 320, 448, 0, 0, 0, 1, "game_over_rel");
        step(0, B_START, 0, 320, 448, 3, 0, 0, 0, "restart");
        step(0, B_NONE,  0, 320, 448, 3, 0, 0, 0, "restart_rel");

        // Full crossing: 14 hops to Y=0, then respawn with level 1.
        for (int k = 1; k <= 14; k++) begin
            step(0, B_UP, 0, 320, 448 - 32 * k, 3, 0, 0, 0, "cross1_up");
            if (k < 14) begin
                step(0, B_NONE, 0, 320, 448 - 32 * k, 3, 0, 0, 0, "cross1_rel");
            end
        end
        step(0, B_NONE, 0, 320, 448, 3, 1, 0, 0, "goal_respawn");

        // Second crossing with a collision on the goal cycle.
        for (int k = 1; k <= 14; k++) begin
            step(0, B_UP, 0, 320, 448 - 32 * k, 3, 1, 0, 0, "cross2_up");
            if (k < 14) begin
                step(0, B_NONE, 0, 320, 448 - 32 * k, 3, 1, 0, 0, "cross2_rel");
            end
        end
        step(0, B_NONE, 1, 320, 0, 2, 1, 1, 0, "goal_and_hit");
        step(0, B_NONE, 0, 320, 0, 2, 1, 1, 0, "goal_hit_hold");

        // Reset mid-freeze.
        step(1, B_UP,   1, 320, 448, 3, 0, 0, 0, "reset_in_hit");
        step(0, B_NONE, 0, 320, 448, 3, 0, 0, 0, "after_reset");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frog_control.md
FROG_CONTROL -- requirements
Module: frog_control

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 32, frog step and grid pitch in pixels.
REQ-002 SHALL have parameter GRID_COLS, default 20, playfield width in tiles.
REQ-003 SHALL have parameter GRID_ROWS, default 15, playfield height in tiles.
REQ-004 SHALL have parameter DEATH_CYCLES, default 25_000_000, freeze time after a hit in clocks.
REQ-005 SHALL have parameter START_LIVES, default 3, lives at game start.
REQ-006 SHALL use one clock and a synchronous, active-high reset: i_Clk  in  1  system clock; i_Reset  in  1  synchronous active-high reset.
REQ-007 SHALL have i_Up, i_Down, i_Left, i_Right  in  1 each  debounced button levels.
REQ-008 SHALL have i_Start  in  1  debounced start button level.
REQ-009 SHALL have i_Has_Collided  in  1  collision flag from the collision checker, one-cycle registered.
REQ-010 SHALL have o_Frog_X, o_Frog_Y  out  10 each  frog top-left pixel position.
REQ-011 SHALL have o_Lives  out  2  remaining lives; o_Level  out  4  completed crossings.
REQ-012 SHALL have o_Hit_Active  out  1  high during death freeze; o_Game_Over  out  1  high in GAME_OVER.

Function
REQ-013 SHALL implement states IDLE, PLAY, HIT, GAME_OVER.
REQ-014 Start position SHALL be X=(GRID_COLS/2)*TILE_SIZE, Y=(GRID_ROWS-1)*TILE_SIZE (320, 448 at defaults).
REQ-015 Button inputs SHALL be rising-edge detected; one tile move per press, held buttons do not repeat.
REQ-016 Moves SHALL apply only in PLAY, one cycle after the rising edge; position updates by exactly TILE_SIZE.
REQ-017 Simultaneous edges SHALL resolve with priority Up > Down > Left > Right; only one move per cycle.
REQ-018 Moves past any playfield edge (X<0, X>(GRID_COLS-1)*TILE_SIZE, Y>(GRID_ROWS-1)*TILE_SIZE) SHALL be ignored; no wrap-around.
REQ-019 IDLE -> PLAY on i_Start rising edge; frog at start, lives=START_LIVES, level=0.
REQ-020 In PLAY, i_Has_Collided=1 SHALL enter HIT next cycle, decrement lives, load freeze counter with DEATH_CYCLES-1.
REQ-021 In PLAY, frog reaching Y=0 with no collision in that cycle SHALL respawn at start next cycle and increment o_Level, saturating at 15.
REQ-022 Collision and goal in the same cycle SHALL resolve as collision.
REQ-023 In HIT, position SHALL hold, moves and collisions SHALL be ignored, o_Hit_Active=1 for exactly DEATH_CYCLES cycles.
REQ-024 At HIT counter zero: lives>0 -> PLAY with frog at start; lives=0 -> GAME_OVER.
REQ-025 In GAME_OVER, o_Game_Over=1, position holds; i_Start rising edge -> PLAY with full reset of lives, level, position.
REQ-026 Button edges pending from HIT or GAME_OVER SHALL not be replayed on return to PLAY.

Reset
REQ-027 i_Reset SHALL, on the next i_Clk edge, force IDLE, frog at start, o_Lives=START_LIVES, o_Level=0, o_Hit_Active=0, o_Game_Over=0, freeze counter=0, edge-detect history=0.
REQ-028 Reset mid-HIT or mid-GAME_OVER SHALL abort with the same values; reset dominates all inputs.

Structure
REQ-029 TILE_SIZE, GRID_COLS, GRID_ROWS and state encodings SHALL live in the shared game constants include used by the collision and rendering blocks.
REQ-030 Rising-edge detection SHALL be a sub-module button_edge, instantiated five times.
REQ-031 Freeze counter width SHALL be $clog2(DEATH_CYCLES)+1 bits; position arithmetic 10-bit unsigned, bounds checked before update.

Verification (DEATH_CYCLES=4)
REQ-032 Reset, Start pulse, Up pulse -> state PLAY, frog (320,448) then (320,416) one cycle after the edge.
REQ-033 Left held 10 cycles from X=0 -> X stays 0; Up+Right same cycle -> only Y decreases by 32.
REQ-034 Collision pulse in PLAY -> o_Hit_Active high exactly 4 cycles, lives 3->2, Up pulses ignored, then frog at (320,448).
REQ-035 Three collisions -> o_Lives=0, o_Game_Over=1; Start pulse -> lives=3, level=0, PLAY.
REQ-036 14 Up presses to Y=0 -> o_Level=1, frog respawns at (320,448); collision asserted on goal cycle -> HIT, level unchanged.
REQ-037 Reset asserted during HIT -> next cycle IDLE, all outputs at reset values.
